// File: rtl/ray_box_pipe.sv
// ray_box_pipe: three-stage ray/AABB slab test for BVH traversal.
// Takes one ray+box beat per cycle over valid/ready. Produces entry/exit t,
// a hit flag and the caller's tag three cycles after acceptance.
// A single global stall (o_valid & ~i_ready) freezes every stage.
// Optional: define RAY_BOX_STATS_EN to add saturating test/hit counters
// (o_test_cnt, o_hit_cnt).
module ray_box_pipe #(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter int TAG_W    = 8,
  parameter int MIN_T    = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [0:1][0:2][WIDTH-1:0]  i_ray,
  input  logic [0:1][0:2][WIDTH-1:0]  i_box,
  input  logic [WIDTH-1:0]            i_t_max,
  input  logic [TAG_W-1:0]            i_tag,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [WIDTH-1:0]            o_t_entry,
  output logic [WIDTH-1:0]            o_t_exit,
  output logic                        o_hit,
  output logic [TAG_W-1:0]            o_tag
`ifdef RAY_BOX_STATS_EN
  ,
  output logic [31:0]                 o_test_cnt,
  output logic [31:0]                 o_hit_cnt
`endif
);

  // Quotient width: one extra bit so (signed min << FRA_BITS) / -1 cannot wrap.
  localparam int NW = WIDTH + FRA_BITS + 1;
  localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MIN_T_W = WIDTH'(MIN_T);

  // Clamp a WIDTH+1-bit difference back into WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_w1(input logic [WIDTH:0] v);
    if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? S_MIN : S_MAX;
    return v[WIDTH-1:0];
  endfunction

  // Clamp a wide quotient into WIDTH bits.
  function automatic logic [WIDTH-1:0] sat_q(input logic [NW-1:0] q);
    if (q[NW-1:WIDTH-1] == '0 || q[NW-1:WIDTH-1] == '1) return q[WIDTH-1:0];
    return q[NW-1] ? S_MIN : S_MAX;
  endfunction

  logic stall, advance;

  assign stall   = o_valid & ~i_ready;
  assign advance = ~stall;
  assign o_ready = ~stall;

  // ---------------- Stage 1: slab offsets and per-axis flags ----------------
  logic [WIDTH-1:0] s1_lo_d [3];
  logic [WIDTH-1:0] s1_hi_d [3];
  logic [2:0]       s1_par_d, s1_in_d;
  logic             s1_degen_d;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_lo_q  [3];
  logic [WIDTH-1:0] s1_hi_q  [3];
  logic [WIDTH-1:0] s1_dir_q [3];
  logic [2:0]       s1_par_q, s1_in_q;
  logic             s1_degen_q;
  logic [WIDTH-1:0] s1_tmax_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Box corners relative to the origin, parallel/inside flags, degenerate box.
  always_comb begin
    // NOTE: give every combinational output a value on all paths (default first), otherwise a latch is inferred.
    s1_degen_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s1_lo_d[k]  = sat_w1({i_box[0][k][WIDTH-1], i_box[0][k]} - {i_ray[0][k][WIDTH-1], i_ray[0][k]});
      s1_hi_d[k]  = sat_w1({i_box[1][k][WIDTH-1], i_box[1][k]} - {i_ray[0][k][WIDTH-1], i_ray[0][k]});
      s1_par_d[k] = (i_ray[1][k] == '0);
      s1_in_d[k]  = ($signed(i_box[0][k]) <= $signed(i_ray[0][k])) &&
                    ($signed(i_ray[0][k]) <= $signed(i_box[1][k]));
      if ($signed(i_box[0][k]) > $signed(i_box[1][k])) s1_degen_d = 1'b1;
    end
  end

  // Stage 1 register; holds while the pipe is stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    if (!i_rstn) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '{default: '0};
      s1_hi_q    <= '{default: '0};
      s1_dir_q   <= '{default: '0};
      s1_par_q   <= '0;
      s1_in_q    <= '0;
      s1_degen_q <= 1'b0;
      s1_tmax_q  <= '0;
      s1_tag_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= i_valid;
      s1_lo_q    <= s1_lo_d;
      s1_hi_q    <= s1_hi_d;
      for (int k = 0; k < 3; k++) s1_dir_q[k] <= i_ray[1][k];
      s1_par_q   <= s1_par_d;
      s1_in_q    <= s1_in_d;
      s1_degen_q <= s1_degen_d;
      s1_tmax_q  <= i_t_max;
      s1_tag_q   <= i_tag;
    end
  end

  // ---------------- Stage 2: per-axis slab distances ----------------
  logic [WIDTH-1:0] s2_near_d [3];
  logic [WIDTH-1:0] s2_far_d  [3];
  logic             s2_pmiss_d;

  for (genvar k = 0; k < 3; k++) begin : g_axis
    logic signed [NW-1:0] num_lo, num_hi, den, q_lo, q_hi;
    logic [WIDTH-1:0]     t0, t1;

    assign num_lo = {s1_lo_q[k][WIDTH-1], s1_lo_q[k], {FRA_BITS{1'b0}}};
    assign num_hi = {s1_hi_q[k][WIDTH-1], s1_hi_q[k], {FRA_BITS{1'b0}}};
    // A zero direction is replaced by 1 so the divider never sees zero;
    // the quotient is discarded for parallel axes anyway.
    assign den    = s1_par_q[k] ? {{(NW-1){1'b0}}, 1'b1}
                                : {{(NW-WIDTH){s1_dir_q[k][WIDTH-1]}}, s1_dir_q[k]};
    assign q_lo   = num_lo / den;
    assign q_hi   = num_hi / den;
    assign t0     = sat_q(q_lo);
    assign t1     = sat_q(q_hi);

    assign s2_near_d[k] = s1_par_q[k] ? S_MIN : (($signed(t0) < $signed(t1)) ? t0 : t1);
    assign s2_far_d[k]  = s1_par_q[k] ? S_MAX : (($signed(t0) < $signed(t1)) ? t1 : t0);
  end

  assign s2_pmiss_d = |(s1_par_q & ~s1_in_q);

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_near_q [3];
  logic [WIDTH-1:0] s2_far_q  [3];
  logic             s2_pmiss_q, s2_degen_q;
  logic [WIDTH-1:0] s2_tmax_q;
  logic [TAG_W-1:0] s2_tag_q;

  // Stage 2 register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s2_valid_q <= 1'b0;
      s2_near_q  <= '{default: '0};
      s2_far_q   <= '{default: '0};
      s2_pmiss_q <= 1'b0;
      s2_degen_q <= 1'b0;
      s2_tmax_q  <= '0;
      s2_tag_q   <= '0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_near_q  <= s2_near_d;
      s2_far_q   <= s2_far_d;
      s2_pmiss_q <= s2_pmiss_d;
      s2_degen_q <= s1_degen_q;
      s2_tmax_q  <= s1_tmax_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  // ---------------- Stage 3: reduce axes and decide hit ----------------
  logic [WIDTH-1:0] entry_d, exit_d;
  logic             hit_d;

  // Entry is the latest near plane, exit the earliest far plane.
  always_comb begin
    entry_d = s2_near_q[0];
    exit_d  = s2_far_q[0];
    for (int k = 1; k < 3; k++) begin
      if ($signed(s2_near_q[k]) > $signed(entry_d)) entry_d = s2_near_q[k];
      if ($signed(s2_far_q[k])  < $signed(exit_d))  exit_d  = s2_far_q[k];
    end
    hit_d = s2_valid_q & ~s2_degen_q & ~s2_pmiss_q &
            ($signed(entry_d) <= $signed(exit_d)) &
            ($signed(exit_d)  >= $signed(MIN_T_W)) &
            ($signed(entry_d) <= $signed(s2_tmax_q));
  end

  logic             valid_q, hit_q;
  logic [WIDTH-1:0] t_entry_q, t_exit_q;
  logic [TAG_W-1:0] tag_q;

  // Output register; held stable while downstream is not ready.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      t_entry_q <= '0;
      t_exit_q  <= '0;
      tag_q     <= '0;
    end else if (advance) begin
      valid_q   <= s2_valid_q;
      hit_q     <= hit_d;
      t_entry_q <= entry_d;
      t_exit_q  <= exit_d;
      tag_q     <= s2_tag_q;
    end
  end

  assign o_valid   = valid_q;
  assign o_hit     = hit_q;
  assign o_t_entry = t_entry_q;
  assign o_t_exit  = t_exit_q;
  assign o_tag     = tag_q;

`ifdef RAY_BOX_STATS_EN
  logic [31:0] test_cnt_q, hit_cnt_q;

  // Count output transfers (and hitting ones); saturate rather than wrap.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      test_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else if (valid_q && i_ready) begin
      if (test_cnt_q != '1)         test_cnt_q <= test_cnt_q + 32'd1;
      if (hit_q && hit_cnt_q != '1) hit_cnt_q  <= hit_cnt_q + 32'd1;
    end
  end

  assign o_test_cnt = test_cnt_q;
  assign o_hit_cnt  = hit_cnt_q;
`endif

endmodule

// File: doc/ray_box_pipe.md
Name: ray_box_pipe

Overview:
- Pipelined, parametrised ray/AABB slab-test unit for BVH traversal. Companion to the triangle-intersection pipeline.
- Accepts one ray and box per cycle over a valid/ready handshake. Produces entry/exit distances, a hit flag and a pass-through tag 3 cycles later.
- Supports full backpressure, parallel-ray (zero direction) handling, and closest-hit culling against a caller-supplied t limit.

Parameters:
- WIDTH, 32: fixed-point word width (signed, two's complement).
- FRA_BITS, 16: fractional bits; 1.0 = 1 << FRA_BITS.
- TAG_W, 8: width of opaque tag carried alongside each beat (node index etc.).
- MIN_T, 0: signed minimum accepted t; exits below this are misses.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_valid  in  1  input beat valid
- o_ready  out  1  unit can accept a beat this cycle
- i_ray  in  [0:1][0:2][WIDTH-1:0]  [0]=origin E, [1]=direction D, signed
- i_box  in  [0:1][0:2][WIDTH-1:0]  [0]=min corner, [1]=max corner, signed
- i_t_max  in  WIDTH  current closest hit; boxes entered beyond it are culled
- i_tag  in  TAG_W  opaque tag
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts output
- o_t_entry  out  WIDTH  max of per-axis near t
- o_t_exit  out  WIDTH  min of per-axis far t
- o_hit  out  1  box hit
- o_tag  out  TAG_W  tag of this beat

Behaviour:
- Reset (async, i_rstn=0): all stage valids, o_valid, o_hit, o_t_entry, o_t_exit and o_tag = 0. o_ready = 1 after reset. In-flight beats are dropped, never emitted.
- Handshake: input transfer when i_valid & o_ready; output transfer when o_valid & i_ready. Global stall = o_valid & ~i_ready.
  - o_ready = ~stall.
  - During stall, all stage registers hold and outputs remain stable.
  - Bubbles do not stall: empty stages advance.
- Latency: exactly 3 cycles from input transfer to o_valid when unstalled. Throughput 1 beat/cycle. Order preserved.
- S1 (register): per axis k:
  - lo_k = box[0][k] - E[k] and hi_k = box[1][k] - E[k], computed in WIDTH+1 bits and saturated to WIDTH.
  - Also registers: par_k = (D[k]==0); in_k = (box[0][k] <= E[k] <= box[1][k]); degen = any box[0][k] > box[1][k]; D, i_t_max, tag.
- S2 (register): per axis:
  - t0 = (lo<<FRA_BITS)/D, t1 = (hi<<FRA_BITS)/D. Truncate toward zero, saturate to [signed min, signed max] of WIDTH.
  - near = min(t0,t1), far = max(t0,t1); negative D therefore swaps slabs.
  - If par_k: near = signed min, far = signed max; if ~in_k the beat is marked miss.
- S3 (register, drives outputs):
  - entry = max(near_x, near_y, near_z); exit = min(far_x, far_y, far_z).
  - hit = ~degen & ~parallel-miss & (entry <= exit) & (exit >= MIN_T) & (entry <= t_max).
  - entry == exit counts as hit (grazing). o_t_entry/o_t_exit are driven raw even on miss.
- Saturated division results compare normally; no special flags.

Optional Feature:
- RAY_BOX_STATS_EN defined: adds ports o_test_cnt (out, 32) and o_hit_cnt (out, 32).
  - Counters increment on each output transfer (o_hit_cnt only when o_hit=1).
  - Counters saturate at 0xFFFFFFFF and reset to 0 on i_rstn.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan (WIDTH=32, FRA_BITS=16, MIN_T=0, i_ready=1 unless stated):
- Front hit: E=(0,0,0), D=(1,1,1)=0x00010000 each, box [1,1,1]-[2,2,2], i_t_max=0x7fffffff -> 3 cycles later o_hit=1, o_t_entry=0x00010000, o_t_exit=0x00020000, tag echoed.
- Negative direction: E=(3,3,3), D=(-1,-1,-1), same box -> o_hit=1, entry=0x00010000, exit=0x00020000. Box behind ray: E=(3,3,3), D=(1,1,1) -> exit=0xFFFF0000, o_hit=0.
- Parallel: E=(0,5,0), D=(1,0,0), box [1,1,1]-[2,2,2] -> o_hit=0. Same with E=(0,1.5,1.5)=0x00018000 -> o_hit=1, entry=0x00010000, exit=0x00020000.
- Cull and degenerate: front-hit case with i_t_max=0x00008000 -> o_hit=0. Box min x=3 > max x=2 -> o_hit=0.
- Backpressure: stream 6 beats, tags 1..6, back-to-back. Drop i_ready for 5 cycles after the first output.
  - While stalled: o_ready=0, outputs stable.
  - All 6 emerge in order with no loss or duplication.
  - With RAY_BOX_STATS_EN: o_test_cnt=6 afterwards.
- Reset mid-stream: assert i_rstn=0 with 3 beats in flight -> o_valid=0 immediately (async). After release, no stale beat appears; the next input gives correct result at latency 3.
